// File: rtl/reg_dump_pkg.sv
// Shared types for the register-dump streamer: FSM states, the record layout
// carried on the output stream, and the default geometry of a dump.
package reg_dump_pkg;

  localparam int NUM_REGS_DEF = 4;
  localparam int ADDR_W_DEF   = 16;
  localparam int DATA_W_DEF   = 32;
  localparam int STRIDE_DEF   = 4;
  localparam int TIMEOUT_DEF  = 16;
  localparam int IDX_W_DEF    = $clog2(NUM_REGS_DEF + 1);

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    EMIT,
    DONE
  } dump_state_e;

  typedef struct packed {
    logic [IDX_W_DEF-1:0]  idx;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
    logic                  err;
    logic                  last;
  } reg_rec_t;

  // Value reported in place of register contents when a read times out.
  localparam logic [DATA_W_DEF-1:0] ERR_DATA = '0;

endpackage

// File: rtl/reg_dump_streamer.sv
// Walks NUM_REGS register addresses over a req/ack read port and streams one
// (idx, addr, data, err, last) record per register on a valid/ready output.
module reg_dump_streamer
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int STRIDE   = STRIDE_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          dump_start_i,
  input  logic [ADDR_W-1:0]             base_addr_i,
  output logic                          rd_req_o,
  output logic [ADDR_W-1:0]             rd_addr_o,
  input  logic                          rd_ack_i,
  input  logic [DATA_W-1:0]             rd_data_i,
  output logic                          rec_valid_o,
  input  logic                          rec_ready_i,
  output logic [$clog2(NUM_REGS+1)-1:0] rec_idx_o,
  output logic [ADDR_W-1:0]             rec_addr_o,
  output logic [DATA_W-1:0]             rec_data_o,
  output logic                          rec_err_o,
  output logic                          rec_last_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [7:0]                    err_count_o
);

  localparam int IDX_W = $clog2(NUM_REGS + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  dump_state_e      state;
  logic [IDX_W-1:0] idx;
  logic [TMO_W-1:0] tmo_cnt;

  // rd_addr_o advances by STRIDE per register, which equals base + idx*STRIDE
  // modulo 2^ADDR_W, so address wrap-around falls out naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      idx         <= '0;
      tmo_cnt     <= '0;
      rd_req_o    <= 1'b0;
      rd_addr_o   <= '0;
      rec_valid_o <= 1'b0;
      rec_idx_o   <= '0;
      rec_addr_o  <= '0;
      rec_data_o  <= '0;
      rec_err_o   <= 1'b0;
      rec_last_o  <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_count_o <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dump_start_i) begin
            state       <= RD_REQ;
            idx         <= '0;
            tmo_cnt     <= '0;
            rd_addr_o   <= base_addr_i;
            rd_req_o    <= 1'b1;
            busy_o      <= 1'b1;
            err_count_o <= '0;
          end
        end
        RD_REQ: begin
          // An ack in the expiry cycle wins over the timeout.
          if (rd_ack_i || (tmo_cnt == TMO_LAST)) begin
            state       <= EMIT;
            rd_req_o    <= 1'b0;
            rec_valid_o <= 1'b1;
            rec_idx_o   <= idx;
            rec_addr_o  <= rd_addr_o;
            rec_last_o  <= (idx == LAST_IDX);
            if (rd_ack_i) begin
              rec_data_o <= rd_data_i;
              rec_err_o  <= 1'b0;
            end else begin
              rec_data_o <= DATA_W'(ERR_DATA);
              rec_err_o  <= 1'b1;
              if (err_count_o != 8'hFF) begin
                err_count_o <= err_count_o + 8'd1;
              end
            end
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        EMIT: begin
          if (rec_ready_i) begin
            rec_valid_o <= 1'b0;
            if (rec_last_o) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              state     <= RD_REQ;
              idx       <= idx + IDX_W'(1);
              tmo_cnt   <= '0;
              rd_addr_o <= rd_addr_o + ADDR_W'(STRIDE);
              rd_req_o  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Scoreboard bench for reg_dump_streamer: directed dumps push expected records,
// an independent monitor pops and compares on every record handshake.
module tb_reg_dump_streamer;
  import reg_dump_pkg::*;

  localparam int NR = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int ST = 4;
  localparam int TO = 16;
  localparam int IW = $clog2(NR + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          dump_start;
  logic [AW-1:0] base_addr;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic [DW-1:0] rd_data;
  logic          rec_valid;
  logic          rec_ready;
  logic [IW-1:0] rec_idx;
  logic [AW-1:0] rec_addr;
  logic [DW-1:0] rec_data;
  logic          rec_err;
  logic          rec_last;
  logic          busy;
  logic          done;
  logic [7:0]    err_count;

  always #5 clk = ~clk;

  reg_dump_streamer #(
    .NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .STRIDE(ST), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .dump_start_i(dump_start), .base_addr_i(base_addr),
    .rd_req_o(rd_req), .rd_addr_o(rd_addr), .rd_ack_i(rd_ack), .rd_data_i(rd_data),
    .rec_valid_o(rec_valid), .rec_ready_i(rec_ready), .rec_idx_o(rec_idx),
    .rec_addr_o(rec_addr), .rec_data_o(rec_data), .rec_err_o(rec_err),
    .rec_last_o(rec_last), .busy_o(busy), .done_o(done), .err_count_o(err_count)
  );

  typedef struct {
    reg_rec_t rec;
    int       req_len;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          exp_e;
  int            applied = 0;
  int            miscompares = 0;
  int            delay_tab[NR];
  logic [AW-1:0] cur_base = '0;
  int            stall_idx = -1;
  int            stall_left = 0;
  int            done_cnt = 0;
  int            last_len = 0;
  int            age = 0;
  int            resp_i;
  reg_rec_t      snap;
  bit            stalled = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Read responder: acks delay_tab[i] cycles after the request rises (-1 = never).
  initial begin
    rd_ack  = 1'b0;
    rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rd_req && !rst) begin
        resp_i = int'(AW'(rd_addr - cur_base) >> 2) & (NR - 1);
        age++;
        if (delay_tab[resp_i] >= 0 && age == delay_tab[resp_i] + 1) begin
          rd_ack  = 1'b1;
          rd_data = 32'hA5A5_0000 + 32'(resp_i);
        end else begin
          rd_ack  = 1'b0;
          rd_data = $urandom;
        end
      end else begin
        if (age != 0) last_len = age;
        age     = 0;
        rd_ack  = 1'b0;
        rd_data = '0;
      end
    end
  end

  // Backpressure generator on the record stream.
  initial begin
    rec_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rec_valid && int'(rec_idx) == stall_idx && stall_left > 0) begin
        rec_ready = 1'b0;
        stall_left--;
      end else begin
        rec_ready = 1'b1;
      end
    end
  end

  // Monitor: record handshakes, hold stability under backpressure, done pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (rec_valid && stalled) begin
        check_output("hold_rec", 64'({rec_idx, rec_addr, rec_data, rec_err, rec_last}), 64'(snap));
        check_output("hold_req_low", 64'(rd_req), 64'(0));
      end
      if (rec_valid && rec_ready) begin
        stalled = 0;
        if (exp_q.size() == 0) begin
          check_output("unexpected_rec", 64'(1), 64'(0));
        end else begin
          exp_e = exp_q.pop_front();
          check_output("rec_idx", 64'(rec_idx), 64'(exp_e.rec.idx));
          check_output("rec_addr", 64'(rec_addr), 64'(exp_e.rec.addr));
          check_output("rec_data", 64'(rec_data), 64'(exp_e.rec.data));
          check_output("rec_err", 64'(rec_err), 64'(exp_e.rec.err));
          check_output("rec_last", 64'(rec_last), 64'(exp_e.rec.last));
          check_output("req_len", 64'(last_len), 64'(exp_e.req_len));
        end
      end else if (rec_valid) begin
        stalled = 1;
        snap    = {rec_idx, rec_addr, rec_data, rec_err, rec_last};
      end else begin
        stalled = 0;
      end
    end
  end

  task automatic push_expected(input logic [AW-1:0] base, input int d0, input int d1,
                               input int d2, input int d3);
    exp_t e;
    cur_base     = base;
    delay_tab[0] = d0;
    delay_tab[1] = d1;
    delay_tab[2] = d2;
    delay_tab[3] = d3;
    for (int i = 0; i < NR; i++) begin
      e.rec.idx  = IW'(i);
      e.rec.addr = base + AW'(i * ST);
      e.rec.err  = (delay_tab[i] < 0);
      e.rec.data = (delay_tab[i] < 0) ? '0 : 32'hA5A5_0000 + 32'(i);
      e.rec.last = (i == NR - 1);
      e.req_len  = (delay_tab[i] < 0) ? TO : delay_tab[i] + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic start_dump(input logic [AW-1:0] base);
    @(posedge clk);
    #1;
    base_addr  = base;
    dump_start = 1'b1;
    @(posedge clk);
    #1;
    dump_start = 1'b0;
  endtask

  // Called one cycle after the start cycle; cycle count is relative to the start cycle.
  task automatic dump_checks(input int done_before, input int exp_err, input int exp_cycles);
    int cycles;
    bit ok;
    cycles = 1;
    ok     = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
      cycles++;
    end
    check_output("done_seen", 64'(ok), 64'(1));
    if (ok) begin
      if (exp_cycles > 0) check_output("start_to_done", 64'(cycles), 64'(exp_cycles));
      check_output("busy_at_done", 64'(busy), 64'(0));
      check_output("err_count", 64'(err_count), 64'(exp_err));
    end else begin
      exp_q.delete();
    end
    @(negedge clk);
    check_output("done_pulse_width", 64'(done), 64'(0));
    check_output("done_count", 64'(done_cnt - done_before), 64'(1));
    check_output("records_drained", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic apply_stimulus(input logic [AW-1:0] base, input int d0, input int d1,
                                input int d2, input int d3, input int s_idx, input int s_n,
                                input int exp_err, input int exp_cycles);
    int done_before;
    stall_idx   = s_idx;
    stall_left  = s_n;
    push_expected(base, d0, d1, d2, d3);
    done_before = done_cnt;
    start_dump(base);
    dump_checks(done_before, exp_err, exp_cycles);
  endtask

  initial begin
    int  done_before;
    bit  found;
    rst        = 1'b1;
    dump_start = 1'b0;
    base_addr  = '0;
    for (int i = 0; i < NR; i++) delay_tab[i] = 1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_rd_req", 64'(rd_req), 64'(0));
    check_output("rst_rd_addr", 64'(rd_addr), 64'(0));
    check_output("rst_rec_valid", 64'(rec_valid), 64'(0));
    check_output("rst_busy", 64'(busy), 64'(0));
    check_output("rst_done", 64'(done), 64'(0));
    check_output("rst_err_count", 64'(err_count), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] nominal dump");
    apply_stimulus(16'h0100, 1, 1, 1, 1, -1, 0, 0, 13);
    $display("[TB] backpressure on idx 1");
    apply_stimulus(16'h0200, 1, 1, 1, 1, 1, 5, 0, 18);
    $display("[TB] timeout on idx 2");
    apply_stimulus(16'h0300, 1, 1, -1, 1, -1, 0, 1, 27);
    $display("[TB] ack in expiry cycle");
    apply_stimulus(16'h0400, 1, 15, 1, 1, -1, 0, 0, 27);
    $display("[TB] address wrap");
    apply_stimulus(16'hFFFC, 1, 1, 1, 1, -1, 0, 0, 13);
    $display("[TB] zero-latency throughput");
    apply_stimulus(16'h0500, 0, 0, 0, 0, -1, 0, 0, 9);

    $display("[TB] start in DONE ignored, start right after accepted");
    push_expected(16'h0600, 0, 0, 0, 0);
    start_dump(16'h0600);
    found = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) begin
        found = 1;
        break;
      end
    end
    check_output("done_seen_first", 64'(found), 64'(1));
    dump_start = 1'b1;
    base_addr  = 16'h0700;
    @(posedge clk);
    #1;
    check_output("start_in_done_busy", 64'(busy), 64'(0));
    check_output("start_in_done_req", 64'(rd_req), 64'(0));
    check_output("first_drained", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    push_expected(16'h0800, 0, 0, 0, 0);
    base_addr   = 16'h0800;
    done_before = done_cnt;
    @(posedge clk);
    #1;
    dump_start = 1'b0;
    dump_checks(done_before, 0, 9);

    $display("[TB] reset mid-dump and restart");
    stall_idx  = 1;
    stall_left = 50;
    push_expected(16'h0900, -1, 1, 1, 1);
    start_dump(16'h0900);
    found = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rec_valid && rec_idx == IW'(1)) begin
        found = 1;
        break;
      end
    end
    check_output("reached_emit_idx1", 64'(found), 64'(1));
    check_output("err_count_pre_rst", 64'(err_count), 64'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    stall_left = 0;
    stall_idx  = -1;
    @(negedge clk);
    check_output("midrst_rd_req", 64'(rd_req), 64'(0));
    check_output("midrst_rec_valid", 64'(rec_valid), 64'(0));
    check_output("midrst_rec_fields", 64'({rec_idx, rec_addr, rec_data, rec_err, rec_last}), 64'(0));
    check_output("midrst_busy", 64'(busy), 64'(0));
    check_output("midrst_err_count", 64'(err_count), 64'(0));
    exp_q.delete();
    done_before = done_cnt;
    repeat (5) @(negedge clk);
    check_output("abandoned_no_done", 64'(done_cnt - done_before), 64'(0));
    check_output("abandoned_idle", 64'({busy, rec_valid, rd_req}), 64'(0));

    push_expected(16'h0A00, 1, 1, 1, 1);
    done_before = done_cnt;
    start_dump(16'h0A00);
    @(posedge clk);
    #1;
    base_addr  = 16'h0B00;
    dump_start = 1'b1;
    @(posedge clk);
    #1;
    dump_start = 1'b0;
    dump_checks(done_before, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #200000;
    miscompares++;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
